// File: rtl/operand_fwd_stage_if.sv
// operand_fwd_stage_if: operand, forwarding and control bundle between decode and the ID/EX stage
interface operand_fwd_stage_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 3
);
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [NSRC*XLEN-1:0] fwd_data;
    logic [NSRC-1:0]      fwd_hit_a;
    logic [NSRC-1:0]      fwd_hit_b;
    logic [XLEN-1:0]      imm_in;
    logic [XLEN-1:0]      pc_in;
    logic                 sel_pc_in;
    logic                 sel_imm_in;
    logic                 nop;
    logic                 stall;
    logic                 flush;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [XLEN-1:0]      alu_x;
    logic [XLEN-1:0]      alu_y;
    logic                 valid_out;
    logic                 busy;

    modport master (
        output rs1_data, rs2_data, fwd_data, fwd_hit_a, fwd_hit_b, imm_in, pc_in,
               sel_pc_in, sel_imm_in, nop, stall, flush,
        input  op_a, op_b, alu_x, alu_y, valid_out, busy
    );

    modport slave (
        input  rs1_data, rs2_data, fwd_data, fwd_hit_a, fwd_hit_b, imm_in, pc_in,
               sel_pc_in, sel_imm_in, nop, stall, flush,
        output op_a, op_b, alu_x, alu_y, valid_out, busy
    );
endinterface

// File: rtl/operand_fwd_stage.sv
// operand_fwd_stage: forwarded-operand select and ID/EX register with stall, flush and nop bubble
module operand_fwd_stage #(
    parameter int XLEN          = 32,
    parameter int NSRC          = 3,
    parameter int BUBBLE_CYCLES = 1
) (
    input logic                clk,
    input logic                rst,
    operand_fwd_stage_if.slave bus
);
    localparam int CW = $clog2(BUBBLE_CYCLES + 1);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t          state;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic [XLEN-1:0] op_a_q, op_b_q, imm_q, pc_q;
    logic [XLEN-1:0] op_a_d, op_b_d, imm_d, pc_d;
    logic            sel_pc_q, sel_imm_q, valid_q;
    logic            sel_pc_d, sel_imm_d, valid_d;
    logic [CW-1:0]   bub_cnt, bub_cnt_d;

    // Forward select: scan from oldest to youngest so the lowest hitting index wins
    always_comb begin
        fwd_a = bus.rs1_data;
        fwd_b = bus.rs2_data;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (bus.fwd_hit_a[i]) fwd_a = bus.fwd_data[i*XLEN +: XLEN];
            if (bus.fwd_hit_b[i]) fwd_b = bus.fwd_data[i*XLEN +: XLEN];
        end
    end

    // Next-state: flush beats an active bubble, which beats nop, which beats stall, else load
    always_comb begin
        state     = (bub_cnt != '0) ? BUBBLE : RUN;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        sel_pc_d  = sel_pc_q;
        sel_imm_d = sel_imm_q;
        valid_d   = valid_q;
        bub_cnt_d = bub_cnt;
        if (bus.flush || (state == RUN && bus.nop)) begin
            op_a_d    = '0;
            op_b_d    = '0;
            imm_d     = '0;
            pc_d      = '0;
            sel_pc_d  = 1'b0;
            sel_imm_d = 1'b0;
            valid_d   = 1'b0;
            bub_cnt_d = bus.flush ? '0 : CW'(BUBBLE_CYCLES);
        end else if (state == BUBBLE) begin
            bub_cnt_d = bub_cnt - CW'(1);
        end else if (!bus.stall) begin
            op_a_d    = fwd_a;
            op_b_d    = fwd_b;
            imm_d     = bus.imm_in;
            pc_d      = bus.pc_in;
            sel_pc_d  = bus.sel_pc_in;
            sel_imm_d = bus.sel_imm_in;
            valid_d   = 1'b1;
        end
    end

    // Stage register bank, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            sel_pc_q  <= 1'b0;
            sel_imm_q <= 1'b0;
            valid_q   <= 1'b0;
            bub_cnt   <= '0;
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            sel_pc_q  <= sel_pc_d;
            sel_imm_q <= sel_imm_d;
            valid_q   <= valid_d;
            bub_cnt   <= bub_cnt_d;
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.alu_x     = sel_pc_q ? pc_q : op_a_q;
    assign bus.alu_y     = sel_imm_q ? imm_q : op_b_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = (state == BUBBLE);
endmodule

// File: tb/tb_operand_fwd_stage.sv
// tb_operand_fwd_stage: scoreboard-driven scenario bench for operand_fwd_stage with a 2-cycle bubble
module tb_operand_fwd_stage;
    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] alu_x;
        logic [31:0] alu_y;
        logic        valid;
        logic        busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t o, e;

    operand_fwd_stage_if #(.XLEN(32), .NSRC(3)) bus ();

    operand_fwd_stage #(.XLEN(32), .NSRC(3), .BUBBLE_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t exp_of(logic [31:0] a, logic [31:0] b, logic [31:0] x, logic [31:0] y, logic v, logic bz);
        return '{op_a: a, op_b: b, alu_x: x, alu_y: y, valid: v, busy: bz};
    endfunction

    function automatic obs_t observe();
        return '{op_a: bus.op_a, op_b: bus.op_b, alu_x: bus.alu_x, alu_y: bus.alu_y, valid: bus.valid_out, busy: bus.busy};
    endfunction

    task automatic idle();
        bus.rs1_data = '0; bus.rs2_data = '0; bus.fwd_data = '0;
        bus.fwd_hit_a = '0; bus.fwd_hit_b = '0; bus.imm_in = '0; bus.pc_in = '0;
        bus.sel_pc_in = 1'b0; bus.sel_imm_in = 1'b0;
        bus.nop = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #2;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 0));
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL reset_initial got %h exp %h", o, e); errors++; end
        rst = 1'b0;
        tick();
        bus.rs1_data = 32'h1234;
        sb.push_back(exp_of(32'h1234, 0, 32'h1234, 0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL load_1234 got %h exp %h", o, e); errors++; end
        #2 rst = 1'b1;
        #1;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 0));
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL reset_midcycle got %h exp %h", o, e); errors++; end
        rst = 1'b0;
        idle();
        tick();
        bus.nop = 1'b1;
        tick();
        bus.nop = 1'b0;
        #2 rst = 1'b1;
        #1;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 0));
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL reset_midbubble got %h exp %h", o, e); errors++; end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        idle();
        bus.rs1_data = 32'h11;
        bus.rs2_data = 32'h99;
        bus.fwd_data = {32'hCC, 32'hBB, 32'hAA};
        bus.fwd_hit_a = 3'b110;
        bus.fwd_hit_b = 3'b100;
        sb.push_back(exp_of(32'hBB, 32'hCC, 32'hBB, 32'hCC, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL fwd_hit_110 got %h exp %h", o, e); errors++; end
        bus.fwd_hit_a = 3'b000;
        bus.fwd_hit_b = 3'b111;
        sb.push_back(exp_of(32'h11, 32'hAA, 32'h11, 32'hAA, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL fwd_no_hit got %h exp %h", o, e); errors++; end
        bus.fwd_hit_a = 3'b101;
        bus.fwd_hit_b = 3'b000;
        sb.push_back(exp_of(32'hAA, 32'h99, 32'hAA, 32'h99, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL fwd_hit_101 got %h exp %h", o, e); errors++; end
    endtask

    task automatic test_mux();
        idle();
        bus.rs1_data = 32'h9;
        bus.rs2_data = 32'h5;
        bus.imm_in = 32'h7F0;
        bus.pc_in = 32'h400;
        bus.sel_pc_in = 1'b1;
        bus.sel_imm_in = 1'b1;
        sb.push_back(exp_of(32'h9, 32'h5, 32'h400, 32'h7F0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL mux_pc_imm got %h exp %h", o, e); errors++; end
        bus.sel_pc_in = 1'b0;
        sb.push_back(exp_of(32'h9, 32'h5, 32'h9, 32'h7F0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL mux_opa_imm got %h exp %h", o, e); errors++; end
    endtask

    task automatic test_bubble();
        idle();
        bus.rs1_data = 32'h55;
        sb.push_back(exp_of(32'h55, 0, 32'h55, 0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL bubble_preload got %h exp %h", o, e); errors++; end
        bus.nop = 1'b1;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 1));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL bubble_edge_n got %h exp %h", o, e); errors++; end
        bus.stall = 1'b1;
        bus.rs1_data = 32'h22;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 1));
        sb.push_back(exp_of(0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 2; k++) begin
            tick();
            o = observe(); e = sb.pop_front(); checks++;
            if (o !== e) begin $display("FAIL bubble_edge_n+%0d got %h exp %h", k, o, e); errors++; end
        end
        bus.stall = 1'b0;
        bus.nop = 1'b0;
        sb.push_back(exp_of(32'h22, 0, 32'h22, 0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL bubble_reload got %h exp %h", o, e); errors++; end
    endtask

    task automatic test_nop_held();
        idle();
        bus.rs1_data = 32'h3;
        bus.nop = 1'b1;
        for (int k = 0; k < 6; k++) sb.push_back(exp_of(0, 0, 0, 0, 0, (k % 3) != 2));
        for (int k = 0; k < 6; k++) begin
            tick();
            o = observe(); e = sb.pop_front(); checks++;
            if (o !== e) begin $display("FAIL nop_held_%0d got %h exp %h", k, o, e); errors++; end
        end
        bus.nop = 1'b0;
    endtask

    task automatic test_stall();
        idle();
        bus.rs1_data = 32'h33;
        sb.push_back(exp_of(32'h33, 0, 32'h33, 0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL stall_preload got %h exp %h", o, e); errors++; end
        bus.stall = 1'b1;
        bus.rs1_data = 32'h44;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(exp_of(32'h33, 0, 32'h33, 0, 1, 0));
            tick();
            o = observe(); e = sb.pop_front(); checks++;
            if (o !== e) begin $display("FAIL stall_hold_%0d got %h exp %h", k, o, e); errors++; end
        end
        bus.stall = 1'b0;
        sb.push_back(exp_of(32'h44, 0, 32'h44, 0, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL stall_release got %h exp %h", o, e); errors++; end
    endtask

    task automatic test_flush();
        idle();
        bus.rs1_data = 32'h66;
        bus.rs2_data = 32'h67;
        tick();
        bus.flush = 1'b1;
        bus.nop = 1'b1;
        bus.stall = 1'b1;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL flush_all_three got %h exp %h", o, e); errors++; end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick();
        bus.nop = 1'b0;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 1));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL flush_count1 got %h exp %h", o, e); errors++; end
        bus.flush = 1'b1;
        sb.push_back(exp_of(0, 0, 0, 0, 0, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL flush_in_bubble got %h exp %h", o, e); errors++; end
        bus.flush = 1'b0;
        bus.rs1_data = 32'h77;
        sb.push_back(exp_of(32'h77, 32'h67, 32'h77, 32'h67, 1, 0));
        tick();
        o = observe(); e = sb.pop_front(); checks++;
        if (o !== e) begin $display("FAIL flush_then_load got %h exp %h", o, e); errors++; end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_mux();
        test_bubble();
        test_nop_held();
        test_stall();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_fwd_stage.md
# operand_fwd_stage

Parametrised operand-forwarding and ID/EX pipeline stage for the RISC-V core. Selects each ALU source operand from the register file or from NSRC prioritised forwarding sources, registers the result together with pc, imm and the mux selects, and drives the final ALU inputs. Adds stall, flush and a programmable multi-cycle bubble on `nop`. Sits between decode/hazard detection and the ALU.

## Interface

- XLEN, 32, datapath width in bits.
- NSRC, 3, number of forwarding sources (≥1); index 0 is youngest and has highest priority.
- BUBBLE_CYCLES, 1, cycles the stage stays frozen after a `nop` is accepted (≥1).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rs1_data  in  XLEN  register-file read port 1.
- rs2_data  in  XLEN  register-file read port 2.
- fwd_data  in  NSRC*XLEN  forwarding values; source i is bits [i*XLEN +: XLEN].
- fwd_hit_a  in  NSRC  source i matches rs1.
- fwd_hit_b  in  NSRC  source i matches rs2.
- imm_in  in  XLEN  decoded immediate.
- pc_in  in  XLEN  instruction PC.
- sel_pc_in  in  1  ALU X takes PC instead of operand A.
- sel_imm_in  in  1  ALU Y takes immediate instead of operand B.
- nop  in  1  request a bubble.
- stall  in  1  hold stage contents.
- flush  in  1  kill stage contents.
- op_a  out  XLEN  registered forwarded operand A.
- op_b  out  XLEN  registered forwarded operand B (store data).
- alu_x  out  XLEN  ALU input X.
- alu_y  out  XLEN  ALU input Y.
- valid_out  out  1  stage holds a real instruction.
- busy  out  1  bubble counter non-zero.

## Operation

- Forward select A (combinational): lowest index i with fwd_hit_a[i]=1 selects fwd_data slice i; no hit selects rs1_data. B identical with fwd_hit_b / rs2_data.
- Stage registers: op_a, op_b, imm_q, pc_q, sel_pc_q, sel_imm_q, valid_out, bub_cnt (width $clog2(BUBBLE_CYCLES+1)).
- Output mux (combinational from registers): alu_x = sel_pc_q ? pc_q : op_a; alu_y = sel_imm_q ? imm_q : op_b.
- busy = (bub_cnt != 0).
- Per-edge priority, highest first:
  1. flush: all stage registers to 0, bub_cnt to 0, valid_out 0.
  2. busy: bub_cnt decrements by 1; all other registers hold (zero); nop and stall ignored.
  3. nop: all stage registers to 0, valid_out 0, bub_cnt loads BUBBLE_CYCLES.
  4. stall: all registers hold.
  5. otherwise load: op_a/op_b from forward selects, imm_q, pc_q, sel bits from inputs, valid_out 1.
- States: RUN (bub_cnt=0) and BUBBLE (bub_cnt>0). RUN→BUBBLE on nop without flush; BUBBLE→RUN when bub_cnt reaches 0 or on flush.
- No arithmetic on datapath; bub_cnt never underflows (decrement only when non-zero).

## Timing

- Reset (async, immediate on rst high): op_a, op_b, imm_q, pc_q, sel bits, bub_cnt, valid_out = 0; so alu_x = alu_y = 0, busy = 0.
- Load latency: inputs sampled at edge N appear on op_a/op_b/alu_x/alu_y after edge N; alu_x/alu_y follow registers with no extra cycle.
- nop accepted at edge N: outputs zero from N; busy high for BUBBLE_CYCLES cycles; first new load at edge N+BUBBLE_CYCLES+1.
- nop held high continuously: one bubble per 1+BUBBLE_CYCLES cycles, re-armed at the first RUN edge.
- flush during bubble cancels remaining count; next edge may load.
- rst mid-bubble or mid-stall: state returns to reset values regardless of clk.

## Test plan

- Reset: rst pulse mid-cycle with op_a=0x1234 loaded -> all outputs 0, busy 0 before next edge.
- Forward priority: rs1=0x11, fwd_hit_a=3'b110, slices {0xCC,0xBB,0xAA} (i=2..0) -> op_a=0xBB after one edge; fwd_hit_a=0 -> op_a=0x11.
- Output mux: op_b path = 0x5, imm_in=0x7F0, pc_in=0x400, sel_pc_in=1, sel_imm_in=1 -> alu_x=0x400, alu_y=0x7F0, op_b=0x5.
- Bubble, BUBBLE_CYCLES=2: nop at edge N with valid data -> outputs 0, valid_out 0, busy high for edges N+1..N+2, stall/nop ignored; rs1=0x22 loads at N+3.
- Stall: load 0x33, then stall=1 for 3 edges while rs1 changes to 0x44 -> op_a stays 0x33; release -> 0x44 next edge.
- Flush vs nop/stall: flush=nop=stall=1 in one cycle -> registers 0, busy 0; flush during bubble count 1 -> busy drops, next edge loads.
